// File: rtl/lsu_mem_port.sv
// Load/store initiator for the doubleword-addressed data_memory: one byte-addressed
// request becomes a read, write, or read-modify-write; loads are extended, misalignment flagged.
module lsu_mem_port #(
  parameter int RISC_V_DATA_WIDTH         = 64,
  parameter int DATA_MEMORY_ADDRESS_WIDTH = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // Request/response handshake: a request transfers on a rising edge where
  // req_valid && req_ready; resp_valid is a single-cycle pulse with no backpressure.
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [DATA_MEMORY_ADDRESS_WIDTH+2:0] req_addr,
  input  logic [1:0]                           req_size,
  input  logic                                 req_unsigned,
  input  logic [RISC_V_DATA_WIDTH-1:0]         req_wdata,
  output logic                                 resp_valid,
  output logic [RISC_V_DATA_WIDTH-1:0]         resp_rdata,
  output logic                                 resp_err,
  output logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] address,
  output logic [RISC_V_DATA_WIDTH-1:0]         w_data,
  output logic                                 ctrl_mem_w,
  output logic                                 ctrl_mem_r,
  input  logic [RISC_V_DATA_WIDTH-1:0]         r_data
);

  localparam int W  = RISC_V_DATA_WIDTH;
  localparam int NB = W / 8;
  localparam int AW = DATA_MEMORY_ADDRESS_WIDTH + 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                               state;
  logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] lat_idx;
  logic [2:0]                           lat_off;
  logic [1:0]                           lat_size;
  logic                                 lat_we;
  logic                                 lat_uns;
  logic [W-1:0]                         lat_wdata;

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

  function automatic logic [W-1:0] extract(input logic [W-1:0] raw, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [W-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'b00:   extract = uns ? {{(W-8){1'b0}}, sh[7:0]}  : {{(W-8){sh[7]}}, sh[7:0]};
      2'b01:   extract = uns ? {{(W-16){1'b0}}, sh[15:0]} : {{(W-16){sh[15]}}, sh[15:0]};
      2'b10:   extract = uns ? {{(W-32){1'b0}}, sh[31:0]} : {{(W-32){sh[31]}}, sh[31:0]};
      default: extract = sh;
    endcase
  endfunction

  // Byte lanes [off, off+2^size) take the store data; every other lane keeps the read value.
  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] wdata,
                                         input logic [2:0] off, input logic [1:0] size);
    logic [NB-1:0] base;
    logic [NB-1:0] lane_mask;
    logic [W-1:0]  wsh;
    for (int i = 0; i < NB; i++) begin
      base[i] = (i < (1 << size));
    end
    lane_mask = base << off;
    wsh       = wdata << {off, 3'b000};
    for (int i = 0; i < NB; i++) begin
      merge[8*i +: 8] = lane_mask[i] ? wsh[8*i +: 8] : old[8*i +: 8];
    end
  endfunction

  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_idx    <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      lat_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      ctrl_mem_w <= 1'b0;
      ctrl_mem_r <= 1'b0;
      address    <= '0;
      w_data     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_idx   <= req_addr[AW-1:3];
            lat_off   <= req_addr[2:0];
            lat_size  <= req_size;
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_wdata <= req_wdata;
            if (misaligned(req_addr[2:0], req_size)) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && req_size == 2'b11) begin
              // Full doubleword store needs no read; write straight away.
              state      <= S_WR;
              ctrl_mem_w <= 1'b1;
              w_data     <= req_wdata;
              address    <= req_addr[AW-1:3];
            end else begin
              state      <= S_RD;
              ctrl_mem_r <= 1'b1;
              address    <= req_addr[AW-1:3];
            end
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          // r_data is valid here for both combinational and registered-read memories.
          ctrl_mem_r <= 1'b0;
          if (lat_we) begin
            state      <= S_WR;
            ctrl_mem_w <= 1'b1;
            w_data     <= merge(r_data, lat_wdata, lat_off, lat_size);
            address    <= lat_idx;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extract(r_data, lat_off, lat_size, lat_uns);
          end
        end
        S_WR: begin
          state      <= S_RESP;
          ctrl_mem_w <= 1'b0;
          w_data     <= '0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: behavioural data_memory, byte-array reference model,
// response/write scoreboards checked by an independent monitor.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [8:0]  address;
  logic [63:0] w_data;
  logic        ctrl_mem_w;
  logic        ctrl_mem_r;
  logic [63:0] r_data;

  lsu_mem_port #(.RISC_V_DATA_WIDTH(64), .DATA_MEMORY_ADDRESS_WIDTH(9)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .w_data(w_data), .ctrl_mem_w(ctrl_mem_w),
    .ctrl_mem_r(ctrl_mem_r), .r_data(r_data)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ---------------- data_memory model (combinational read) ----------------
  logic [63:0] mem [0:511];

  function automatic logic [63:0] init_word(input int i);
    if (i == 0)      init_word = 64'h0123456789ABCDEF;
    else if (i == 1) init_word = 64'hDEADBEEFDEADBEEF;
    else             init_word = {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'hA5A55A5A};
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ctrl_mem_w) mem[address] <= w_data;
    end
  end
  assign r_data = ctrl_mem_r ? mem[address] : 64'h0;

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] ref_mem [0:4095];

  function automatic logic [63:0] ref_dword(input int idx);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_mem[idx*8 + b];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];      // {err, rdata}
  int          exp_cyc_q[$];
  logic [72:0] wr_q[$];       // {index, data}
  int          wr_cyc_q[$];
  int          rd_lo = 1, rd_hi = 0;
  logic [8:0]  rd_idx = '0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check64("strobe_overlap", 64'(ctrl_mem_r & ctrl_mem_w), 64'd0);
      if (!ctrl_mem_w) check64("w_data_idle", w_data, 64'd0);
      check64("ctrl_mem_r", 64'(ctrl_mem_r), 64'((cyc >= rd_lo) && (cyc <= rd_hi)));
      if (ctrl_mem_r) check64("rd_address", 64'(address), 64'(rd_idx));
      if (ctrl_mem_w) begin
        if (wr_q.size() == 0) begin
          check64("unexpected_write", 64'(ctrl_mem_w), 64'd0);
        end else begin
          logic [72:0] e;
          int ec;
          e  = wr_q.pop_front();
          ec = wr_cyc_q.pop_front();
          check64("wr_cycle", 64'(cyc), 64'(ec));
          check64("wr_address", 64'(address), 64'(e[72:64]));
          check64("wr_data", w_data, e[63:0]);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check64("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          logic [64:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check64("resp_cycle", 64'(cyc), 64'(ec));
          check64("resp_err", 64'(resp_err), 64'(e[64]));
          check64("resp_rdata", resp_rdata, e[63:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [11:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata);
    int nb, lat, c0, a;
    logic err;
    logic [63:0] rd;
    @(posedge clk); #1;
    c0 = cyc;
    check64("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;

    nb  = 1 << size;
    a   = int'(addr);
    err = (a % nb) != 0;
    rd  = '0;
    if (err)                    lat = 1;
    else if (we && size == 2'b11) lat = 2;
    else if (we)                lat = 4;
    else                        lat = 3;
    if (!err && we) begin
      for (int b = 0; b < nb; b++) ref_mem[a + b] = wdata[8*b +: 8];
      wr_q.push_back({addr[11:3], ref_dword(a / 8)});
      wr_cyc_q.push_back(c0 + lat - 1);
    end else if (!err) begin
      for (int b = 0; b < nb; b++) rd[8*b +: 8] = ref_mem[a + b];
      if (!uns && ref_mem[a + nb - 1][7])
        for (int b = nb; b < 8; b++) rd[8*b +: 8] = 8'hFF;
    end
    exp_q.push_back({err, rd});
    exp_cyc_q.push_back(c0 + lat);
    if (!err && !(we && size == 2'b11)) begin
      rd_lo = c0 + 1; rd_hi = c0 + 2; rd_idx = addr[11:3];
    end

    // While busy, throw random requests at the block; they must be ignored.
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1));
      req_addr = 12'($urandom_range(0, 4095));
      req_size = 2'($urandom_range(0, 3));
      req_wdata = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic random_access();
    logic we, uns;
    logic [1:0] size;
    logic [11:0] addr;
    int idx, off;
    we   = 1'($urandom_range(0, 1));
    uns  = 1'($urandom_range(0, 1));
    size = 2'($urandom_range(0, 3));
    idx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 7));
    off  = int'($urandom_range(0, 7));
    if ($urandom_range(0, 9) < 7) off = off & ~((1 << size) - 1);
    addr = 12'(idx * 8 + off);
    issue(we, addr, size, uns, {$urandom, $urandom});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] w;
    int c0;
    for (int i = 0; i < 512; i++) begin
      w = init_word(i);
      for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = w[8*b +: 8];
    end

    repeat (2) @(posedge clk);
    #1;
    check64("rst_req_ready", 64'(req_ready), 64'd1);
    check64("rst_resp_valid", 64'(resp_valid), 64'd0);
    check64("rst_resp_err", 64'(resp_err), 64'd0);
    check64("rst_resp_rdata", resp_rdata, 64'd0);
    check64("rst_ctrl_mem_w", 64'(ctrl_mem_w), 64'd0);
    check64("rst_ctrl_mem_r", 64'(ctrl_mem_r), 64'd0);
    check64("rst_address", 64'(address), 64'd0);
    check64("rst_w_data", w_data, 64'd0);
    rst = 1'b0;

    // Directed cases
    issue(1'b0, 12'h000, 2'b00, 1'b0, 64'd0);
    issue(1'b0, 12'h000, 2'b00, 1'b1, 64'd0);
    issue(1'b0, 12'h007, 2'b00, 1'b0, 64'd0);
    issue(1'b1, 12'h00A, 2'b01, 1'b0, 64'h0000000000001234);
    issue(1'b0, 12'h008, 2'b11, 1'b0, 64'd0);
    issue(1'b1, 12'hD58, 2'b11, 1'b0, 64'hFEDCBA9876543210);
    issue(1'b0, 12'hD58, 2'b11, 1'b0, 64'd0);
    issue(1'b0, 12'h002, 2'b10, 1'b0, 64'd0);
    issue(1'b1, 12'h008, 2'b11, 1'b0, 64'h8000000000000000);
    issue(1'b0, 12'h00C, 2'b10, 1'b0, 64'd0);
    issue(1'b0, 12'h00C, 2'b10, 1'b1, 64'd0);
    issue(1'b1, 12'h013, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFF5A);
    issue(1'b1, 12'h01C, 2'b10, 1'b0, 64'h00000000CAFEF00D);
    issue(1'b0, 12'h018, 2'b11, 1'b0, 64'd0);

    for (int n = 0; n < 250; n++) random_access();

    // Reset pulse during the write cycle of a sub-doubleword store
    @(posedge clk); #1;
    c0 = cyc;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h02B; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 64'h00000000000000C3;
    rd_lo = c0 + 1; rd_hi = c0 + 2; rd_idx = 9'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check64("wr_before_rst", 64'(ctrl_mem_w), 64'd1);
    #2 rst = 1'b1;
    #1;
    check64("wr_async_drop", 64'(ctrl_mem_w), 64'd0);
    check64("w_data_async_drop", w_data, 64'd0);
    check64("resp_after_rst", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check64("ready_after_rst", 64'(req_ready), 64'd1);
    repeat (6) @(posedge clk);

    issue(1'b0, 12'h028, 2'b11, 1'b0, 64'd0);
    repeat (3) @(posedge clk);
    #1;

    check64("resp_q_drained", 64'(exp_q.size()), 64'd0);
    check64("wr_q_drained", 64'(wr_q.size()), 64'd0);
    for (int i = 0; i < 512; i++) check64("mem_final", mem[i], ref_dword(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
